// File: rtl/gpmc_reg_bridge.sv
// Register/FIFO bridge behind the GPMC synchronous slave: decodes ID/CTRL/STATUS/
// FIFO_DATA/SCRATCH and drains the pixel FIFO onto a valid/ready stream.
module gpmc_reg_bridge #(
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DATA_WIDTH = 16,
    parameter int                    FIFO_AW    = 8,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 16'hCC01
) (
    input  logic                  gpmc_clk,
    input  logic                  rst,
    input  logic                  rd_en,
    input  logic                  wr_en,
    input  logic                  address_valid,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] stream_data,
    output logic                  stream_valid,
    input  logic                  stream_ready,
    output logic                  enable,
    output logic                  overflow
);

    localparam int CW    = FIFO_AW + 1;
    localparam int DEPTH = 1 << FIFO_AW;

    localparam logic [ADDR_WIDTH-1:0] A_ID      = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] A_CTRL    = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] A_STATUS  = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] A_FIFO    = ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] A_SCRATCH = ADDR_WIDTH'(4);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] ctrl_q, ctrl_d;
    logic [DATA_WIDTH-1:0] scratch_q, scratch_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  overflow_q, overflow_d;
    logic [FIFO_AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;

    logic                  wr_sel_s, full_s, empty_s, pop_s;
    logic                  push_req_s, push_ok_s, flush_s, status_rd_s;
    logic [DATA_WIDTH-1:0] status_s;

    // count never exceeds DEPTH, so its top bit alone marks full
    assign full_s       = count_q[FIFO_AW];
    assign empty_s      = (count_q == CW'(0));
    assign stream_valid = ctrl_q[0] && !empty_s;
    assign stream_data  = mem_q[rd_ptr_q];
    assign enable       = ctrl_q[0];
    assign overflow     = overflow_q;
    assign rd_data      = rd_data_q;

    assign wr_sel_s    = wr_en && address_valid;
    assign pop_s       = stream_valid && stream_ready;
    assign push_req_s  = wr_sel_s && (address == A_FIFO);
    assign flush_s     = wr_sel_s && (address == A_CTRL) && wr_data[1];
    assign push_ok_s   = push_req_s && (!full_s || pop_s);
    assign status_rd_s = rd_en && address_valid && (address == A_STATUS);

    // STATUS word assembly
    always_comb begin
        status_s        = '0;
        status_s[15]    = overflow_q;
        status_s[14]    = full_s;
        status_s[13]    = empty_s;
        status_s[12:0]  = 13'(count_q);
    end

    // Read decode; registered so data stays stable through the GPMC data phase
    always_comb begin
        rd_data_d = '0;
        if (address_valid) begin
            case (address)
                A_ID:      rd_data_d = ID_VALUE;
                A_CTRL:    rd_data_d = ctrl_q;
                A_STATUS:  rd_data_d = status_s;
                A_SCRATCH: rd_data_d = scratch_q;
                default:   rd_data_d = '0;
            endcase
        end else begin
            rd_data_d = '0;
        end
    end

    // Register writes and sticky overflow (a new overflow beats clear-on-read)
    always_comb begin
        ctrl_d     = ctrl_q;
        scratch_d  = scratch_q;
        overflow_d = overflow_q;
        if (wr_sel_s && (address == A_CTRL)) begin
            ctrl_d = wr_data & ~DATA_WIDTH'(2);
        end else begin
            ctrl_d = ctrl_q;
        end
        if (wr_sel_s && (address == A_SCRATCH)) begin
            scratch_d = wr_data;
        end else begin
            scratch_d = scratch_q;
        end
        if (push_req_s && !push_ok_s) begin
            overflow_d = 1'b1;
        end else if (status_rd_s) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // FIFO pointer and occupancy update
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_s) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_ok_s, pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers
    always_ff @(posedge gpmc_clk) begin
        if (rst) begin
            ctrl_q     <= '0;
            scratch_q  <= '0;
            rd_data_q  <= '0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            ctrl_q     <= ctrl_d;
            scratch_q  <= scratch_d;
            rd_data_q  <= rd_data_d;
            overflow_q <= overflow_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity
    always_ff @(posedge gpmc_clk) begin
        if (!rst && push_ok_s && !flush_s) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: tb/tb_gpmc_reg_bridge.sv
// Self-checking bench for gpmc_reg_bridge (FIFO_AW = 2, depth 4) using a queue-based model.
module tb_gpmc_reg_bridge;

    logic        gpmc_clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_en = 1'b0, wr_en = 1'b0, address_valid = 1'b0;
    logic [15:0] address = 16'h0000, wr_data = 16'h0000;
    logic [15:0] rd_data, stream_data;
    logic        stream_valid, stream_ready = 1'b0;
    logic        enable, overflow;

    int total = 0;
    int bad   = 0;

    logic [15:0] q[$];
    logic [15:0] m_ctrl = 16'h0000;
    logic [15:0] m_scratch = 16'h0000;
    logic        m_ovf = 1'b0;

    gpmc_reg_bridge #(
        .ADDR_WIDTH(16), .DATA_WIDTH(16), .FIFO_AW(2), .ID_VALUE(16'hCC01)
    ) dut (
        .gpmc_clk(gpmc_clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en),
        .address_valid(address_valid), .address(address), .wr_data(wr_data),
        .rd_data(rd_data), .stream_data(stream_data), .stream_valid(stream_valid),
        .stream_ready(stream_ready), .enable(enable), .overflow(overflow)
    );

    always #5 gpmc_clk = ~gpmc_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] m_read(input logic [15:0] a);
        case (a)
            16'h0000: return 16'hCC01;
            16'h0001: return m_ctrl;
            16'h0002: return {m_ovf, 1'(q.size() == 4), 1'(q.size() == 0), 13'(q.size())};
            16'h0004: return m_scratch;
            default:  return 16'h0000;
        endcase
    endfunction

    // One bus cycle: drive inputs, check stream side, advance the model, check rd_data
    task automatic step(input logic r, input logic w, input logic av,
                        input logic [15:0] a, input logic [15:0] d, input logic rdy);
        logic [15:0] e_rd;
        logic        pop, ovf_set;
        int          sz;
        rd_en = r; wr_en = w; address_valid = av; address = a; wr_data = d; stream_ready = rdy;
        #1;
        sz = q.size();
        chk("enable", enable, m_ctrl[0]);
        chk("overflow", overflow, m_ovf);
        chk("stream_valid", stream_valid, m_ctrl[0] && sz > 0);
        if (m_ctrl[0] && sz > 0) chk("stream_data", stream_data, q[0]);
        e_rd = av ? m_read(a) : 16'h0000;
        pop = m_ctrl[0] && (sz > 0) && rdy;
        ovf_set = 1'b0;
        if (rst) begin
            q.delete();
            m_ctrl = 16'h0000; m_scratch = 16'h0000; m_ovf = 1'b0; e_rd = 16'h0000;
        end else begin
            if (pop) void'(q.pop_front());
            if (w && av) begin
                case (a)
                    16'h0001: begin
                        m_ctrl = d & 16'hFFFD;
                        if (d[1]) q.delete();
                    end
                    16'h0003: begin
                        if (sz < 4 || pop) q.push_back(d);
                        else ovf_set = 1'b1;
                    end
                    16'h0004: m_scratch = d;
                    default: ;
                endcase
            end
            if (ovf_set) m_ovf = 1'b1;
            else if (r && av && a == 16'h0002) m_ovf = 1'b0;
        end
        @(posedge gpmc_clk);
        #1;
        chk("rd_data", rd_data, e_rd);
    endtask

    initial begin
        // reset
        rst = 1'b1;
        step(0, 0, 0, 16'h0, 16'h0, 0);
        step(0, 0, 0, 16'h0, 16'h0, 0);
        rst = 1'b0;
        chk("rst_rd_data", rd_data, 16'h0000);
        chk("rst_valid", stream_valid, 1'b0);

        // ID and STATUS after reset
        step(0, 0, 1, 16'h0000, 16'h0, 0);
        chk("id", rd_data, 16'hCC01);
        step(0, 0, 1, 16'h0002, 16'h0, 0);
        chk("status_rst", rd_data, 16'h2000);

        // scratch and unmapped
        step(0, 1, 1, 16'h0004, 16'hA5A5, 0);
        step(0, 0, 1, 16'h0004, 16'h0, 0);
        chk("scratch", rd_data, 16'hA5A5);
        step(0, 1, 1, 16'h0007, 16'h1234, 0);
        step(0, 0, 1, 16'h0007, 16'h0, 0);
        chk("unmapped", rd_data, 16'h0000);
        step(0, 0, 1, 16'h0004, 16'h0, 0);
        chk("scratch_kept", rd_data, 16'hA5A5);
        step(0, 1, 0, 16'h0004, 16'h5555, 0);
        step(0, 0, 1, 16'h0004, 16'h0, 0);
        chk("wr_no_av", rd_data, 16'hA5A5);

        // push three while disabled, then enable and drain
        for (int i = 1; i <= 3; i++) step(0, 1, 1, 16'h0003, 16'(i), 1);
        step(0, 0, 1, 16'h0002, 16'h0, 1);
        chk("status_3", rd_data, 16'h0003);
        chk("disabled_valid", stream_valid, 1'b0);
        step(0, 1, 1, 16'h0001, 16'h0001, 1);
        for (int i = 1; i <= 3; i++) begin
            chk("drain_order", stream_data, 16'(i));
            step(0, 0, 0, 16'h0, 16'h0, 1);
        end
        step(0, 0, 1, 16'h0002, 16'h0, 1);
        chk("status_drained", rd_data, 16'h2000);

        // overflow with stream disabled
        step(0, 1, 1, 16'h0001, 16'h0000, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 1, 16'h0003, 16'h0011 + 16'(i), 0);
        chk("ovf_out", overflow, 1'b1);
        step(1, 0, 1, 16'h0002, 16'h0, 0);
        chk("status_ovf", rd_data, 16'hC004);
        step(0, 0, 1, 16'h0002, 16'h0, 0);
        chk("status_cleared", rd_data, 16'h4004);

        // full FIFO, streaming, push every cycle across pointer wrap
        step(0, 1, 1, 16'h0001, 16'h0001, 1);
        for (int i = 0; i < 10; i++) step(0, 1, 1, 16'h0003, 16'h0020 + 16'(i), 1);
        step(0, 0, 1, 16'h0002, 16'h0, 1);
        chk("status_full_stream", rd_data, 16'h4004);
        chk("no_ovf", overflow, 1'b0);

        // flush
        step(0, 1, 1, 16'h0001, 16'h0002, 0);
        step(0, 1, 1, 16'h0003, 16'h0BEE, 0);
        step(0, 1, 1, 16'h0003, 16'h0BEF, 0);
        step(0, 1, 1, 16'h0001, 16'h0002, 0);
        step(0, 0, 1, 16'h0002, 16'h0, 0);
        chk("status_flush", rd_data, 16'h2000);
        step(0, 0, 1, 16'h0001, 16'h0, 0);
        chk("ctrl_flush", rd_data, 16'h0000);

        // reset mid-stream
        step(0, 1, 1, 16'h0001, 16'hF001, 0);
        step(0, 1, 1, 16'h0003, 16'h0077, 0);
        step(0, 1, 1, 16'h0003, 16'h0078, 0);
        step(0, 1, 1, 16'h0004, 16'h0055, 0);
        chk("pre_rst_valid", stream_valid, 1'b1);
        rst = 1'b1;
        step(0, 0, 1, 16'h0001, 16'h0, 0);
        rst = 1'b0;
        chk("mid_rst_valid", stream_valid, 1'b0);
        chk("mid_rst_enable", enable, 1'b0);
        step(0, 0, 1, 16'h0004, 16'h0, 0);
        chk("mid_rst_scratch", rd_data, 16'h0000);
        step(0, 0, 1, 16'h0001, 16'h0, 0);
        chk("mid_rst_ctrl", rd_data, 16'h0000);

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            logic [15:0] a, d;
            a = 16'($urandom_range(0, 5));
            d = 16'($urandom);
            if (a == 16'h0001 && $urandom_range(0, 3) != 0) d[1] = 1'b0;
            rst = ($urandom_range(0, 99) == 0);
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) != 0), a, d, 1'($urandom_range(0, 1)));
            rst = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gpmc_reg_bridge.md
Name: gpmc_reg_bridge

Overview:
Register/FIFO bridge that sits directly downstream of the GPMC synchronous slave. It consumes that slave's host-side strobes (rd_en, wr_en, address_valid, address, data_out) and returns read data on its data_in. It decodes a small register map: ID, control, status, scratch, and a pixel-FIFO write port. FIFO contents are presented to the LED-driver side on a valid/ready stream.

Parameters:
ADDR_WIDTH, 16, width of the word address from the GPMC slave.
DATA_WIDTH, 16, width of the register and FIFO word.
FIFO_AW, 8, FIFO address bits; depth = 2**FIFO_AW (max 12).
ID_VALUE, 16'hCC01, constant returned by the ID register.

Ports:
gpmc_clk  input  1  sole clock, same clock as the GPMC slave.
rst  input  1  synchronous, active-high reset.
rd_en  input  1  one-cycle read strobe from the GPMC slave.
wr_en  input  1  one-cycle write strobe from the GPMC slave.
address_valid  input  1  high while the GPMC slave holds a latched address.
address  input  ADDR_WIDTH  latched word address.
wr_data  input  DATA_WIDTH  write data; connects to the slave's data_out.
rd_data  output  DATA_WIDTH  read data; connects to the slave's data_in.
stream_data  output  DATA_WIDTH  FIFO head word.
stream_valid  output  1  head word valid; gated by enable.
stream_ready  input  1  downstream accepts the head word.
enable  output  1  CTRL[0].
overflow  output  1  sticky overflow flag, STATUS[15].

Behaviour:
- Clocking and reset: single clock gpmc_clk; reset is synchronous and active-high (rst). All state changes on the rising edge of gpmc_clk.
- Reset values:
  - rd_data = 0
  - CTRL = 0, so enable = 0
  - SCRATCH = 0
  - overflow = 0
  - FIFO empty: read pointer = write pointer = count = 0
  - stream_valid = 0
  - stream_data is don't-care while stream_valid = 0
- Register map (word address):
  - 0x0000 ID: read-only, returns ID_VALUE.
  - 0x0001 CTRL: read/write.
    - [0] enable.
    - [1] flush: write-1 self-clearing, always reads 0.
    - [15:2] read/write storage.
  - 0x0002 STATUS: read-only.
    - [15] overflow.
    - [14] full.
    - [13] empty.
    - [12:0] count, zero-extended.
  - 0x0003 FIFO_DATA: write-only, each write pushes wr_data; reads return 0.
  - 0x0004 SCRATCH: read/write.
  - Unmapped addresses: reads return 0, writes are ignored.
- Read path:
  - rd_data is registered: each cycle rd_data <= decode(address) when address_valid = 1, else 0.
  - Latency is 1 cycle from address change. The value must be stable throughout the data phase because the GPMC slave drives it straight to the pins.
  - rd_en produces no data change; it is used only for side effects.
- Write path: on wr_en = 1, the register selected by address is updated at that edge. wr_en with address_valid = 0 is ignored.
- STATUS clear-on-read: rd_en = 1 at address 0x0002 clears overflow at that edge. If an overflow event occurs in the same cycle, set wins and overflow stays 1.
- FIFO push: write to 0x0003.
  - Accepted when count < 2**FIFO_AW, or when a pop occurs in the same cycle.
  - Otherwise the word is dropped and overflow is set.
- FIFO pop: occurs when stream_valid && stream_ready.
  - stream_valid = enable && !empty.
  - stream_data = mem[rd_ptr]. Use a first-word-fall-through register so stream_data is valid in the same cycle as stream_valid.
  - Push-to-valid latency on an empty FIFO: at most 2 cycles.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Pointers: wrap modulo 2**FIFO_AW. count is FIFO_AW+1 bits.
- Flush:
  - Writing CTRL[1] = 1 resets the pointers and count at that edge.
  - A same-cycle push is discarded.
  - overflow is unaffected.
  - CTRL[0] takes the written value.
- enable = 0: stream_valid is held 0; pushes still accepted; no pops occur.
- rst mid-operation: FIFO contents discarded, all registers return to reset values next edge.

Test Plan:
- After rst, read 0x0000 -> rd_data = 16'hCC01 one cycle after address_valid. Read 0x0002 -> 16'h2000 (empty, count 0).
- Write 0x0004 = 16'hA5A5 then read 0x0004 -> 16'hA5A5. Write 0x0007 = 16'h1234 -> no state change; read 0x0007 -> 0.
- enable = 0, push 3 words 0x0001..0x0003 -> STATUS = 16'h0003, stream_valid = 0. Write CTRL = 1 with stream_ready = 1 -> words 1, 2, 3 appear in order on consecutive cycles; STATUS then reads 16'h2000.
- With FIFO_AW = 2, push 5 words with stream disabled:
  - STATUS reads 16'hC004 (overflow, full, count 4).
  - overflow output = 1.
  - A second STATUS read returns 16'h4004.
- Full FIFO, enable = 1, stream_ready = 1, push every cycle -> no overflow, count stays 4, output order preserved across pointer wrap.
- Push 2 words, write CTRL = 16'h0002 -> empty, count 0, CTRL reads 0; assert rst mid-stream -> stream_valid = 0 and all registers zero next cycle.
